// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer: multi-cycle wide add/subtract engine.
// One CHUNK_WIDTH-bit carry-select adder is stepped over the operands,
// LSB chunk first, with a registered carry linking one chunk to the next.
//
// carry_select_adder ports:
//   a, b  : WIDTH-bit addends
//   cin   : carry-in
//   sum   : WIDTH-bit sum
//   cout  : carry-out
//
// wide_add_sequencer ports:
//   clk, rst             : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready  : operand handshake (A, B, Cin, SUB sampled on accept)
//   A, B                 : DATA_WIDTH-bit operands
//   Cin                  : carry-in (add) / borrow-in (sub)
//   SUB                  : 0 -> S = A+B+Cin, 1 -> S = A-B-Cin
//   out_valid / out_ready: result handshake
//   S, Cout, Ovf         : result, carry-out of MSB (sub: 1 = no borrow), signed overflow
//   busy                 : high while chunks are being processed

module carry_select_adder #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NBLK = WIDTH / BLOCK;

  if (BLOCK < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_block
    $error("carry_select_adder: WIDTH must be a multiple of BLOCK");
  end

  logic [NBLK:0] c;

  assign c[0] = cin;

  // Each block precomputes its sum for both possible incoming carries;
  // the real carry only drives a mux, so the carry path is one mux per block.
  for (genvar i = 0; i < NBLK; i++) begin : g_blk
    logic [BLOCK:0] s0;
    logic [BLOCK:0] s1;

    assign s0 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]};
    assign s1 = {1'b0, a[i*BLOCK +: BLOCK]} + {1'b0, b[i*BLOCK +: BLOCK]}
                + {{BLOCK{1'b0}}, 1'b1};

    assign sum[i*BLOCK +: BLOCK] = c[i] ? s1[BLOCK-1:0] : s0[BLOCK-1:0];
    assign c[i+1]                = c[i] ? s1[BLOCK] : s0[BLOCK];
  end

  assign cout = c[NBLK];

endmodule

// state | meaning
// IDLE  | waiting for operands, in_ready = 1
// RUN   | processing chunk cnt (0 .. CHUNKS-1), busy = 1
// DONE  | result on S/Cout/Ovf, out_valid = 1, may accept next operands
module wide_add_sequencer #(
  parameter int DATA_WIDTH  = 128,
  parameter int CHUNK_WIDTH = 32,
  parameter int BLOCK_SIZE  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  Cin,
  input  logic                  SUB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] S,
  output logic                  Cout,
  output logic                  Ovf,
  output logic                  busy
);

  localparam int CHUNKS = (CHUNK_WIDTH > 0) ? DATA_WIDTH / CHUNK_WIDTH : 1;
  localparam int CNT_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHUNKS - 1);

  if (CHUNK_WIDTH < 1 || (DATA_WIDTH % CHUNK_WIDTH) != 0 || DATA_WIDTH < CHUNK_WIDTH) begin : g_bad_chunk
    $error("wide_add_sequencer: DATA_WIDTH must be a multiple of CHUNK_WIDTH");
  end
  if (BLOCK_SIZE < 1 || (CHUNK_WIDTH % BLOCK_SIZE) != 0) begin : g_bad_blk
    $error("wide_add_sequencer: CHUNK_WIDTH must be a multiple of BLOCK_SIZE");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    carry;
  // Operand registers shift right one chunk per RUN cycle, so the chunk
  // being worked on is always in the low CHUNK_WIDTH bits.
  logic [DATA_WIDTH-1:0]   a_reg;
  logic [DATA_WIDTH-1:0]   b_reg;
  logic [CHUNK_WIDTH-1:0]  chunk_sum;
  logic                    chunk_cout;
  logic [DATA_WIDTH-1:0]   res_next;
  logic                    accept;
  logic                    msb_cin;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);

  carry_select_adder #(
    .WIDTH (CHUNK_WIDTH),
    .BLOCK (BLOCK_SIZE)
  ) u_adder (
    .a    (a_reg[CHUNK_WIDTH-1:0]),
    .b    (b_reg[CHUNK_WIDTH-1:0]),
    .cin  (carry),
    .sum  (chunk_sum),
    .cout (chunk_cout)
  );

  // Result assembly: finished chunks shift down from the top, so after the
  // last chunk the full result is in order. Only the not-yet-final upper part
  // needs storage; the last chunk goes straight into S.
  if (CHUNKS > 1) begin : g_res
    logic [DATA_WIDTH-CHUNK_WIDTH-1:0] res_q;

    assign res_next = {chunk_sum, res_q};

    always_ff @(posedge clk) begin
      if (rst) begin
        res_q <= '0;
      end else if (state == RUN) begin
        res_q <= res_next[DATA_WIDTH-1:CHUNK_WIDTH];
      end
    end
  end else begin : g_res_single
    assign res_next = chunk_sum;
  end

  // On the final chunk the low operand bits hold the original MSB chunk.
  assign msb_cin = chunk_sum[CHUNK_WIDTH-1] ^ a_reg[CHUNK_WIDTH-1] ^ b_reg[CHUNK_WIDTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      S     <= '0;
      Cout  <= 1'b0;
      Ovf   <= 1'b0;
    end else if (accept) begin
      // Subtraction is A + ~B + 1 - Cin: invert B and flip the carry-in.
      state <= RUN;
      cnt   <= '0;
      carry <= Cin ^ SUB;
      a_reg <= A;
      b_reg <= B ^ {DATA_WIDTH{SUB}};
    end else begin
      case (state)
        RUN: begin
          a_reg <= a_reg >> CHUNK_WIDTH;
          b_reg <= b_reg >> CHUNK_WIDTH;
          carry <= chunk_cout;
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) begin
            state <= DONE;
            S     <= res_next;
            Cout  <= chunk_cout;
            Ovf   <= msb_cin ^ chunk_cout;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Bench for wide_add_sequencer: a default 128/32/16 instance and a 32/32/8
// instance, both checked every cycle against an arithmetic reference model,
// plus directed literal checks on the default instance.
module tb_wide_add_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default instance
  logic         rst0, iv0, ir0, ov0, or0, bsy0, cin0, sub0, cout0, ovf0;
  logic [127:0] a0, b0, s0;
  // single-chunk instance
  logic         rst1, iv1, ir1, ov1, or1, bsy1, cin1, sub1, cout1, ovf1;
  logic [31:0]  a1, b1, s1;

  wide_add_sequencer dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .A(a0), .B(b0),
    .Cin(cin0), .SUB(sub0), .out_valid(ov0), .out_ready(or0), .S(s0),
    .Cout(cout0), .Ovf(ovf0), .busy(bsy0)
  );

  wide_add_sequencer #(.DATA_WIDTH(32), .CHUNK_WIDTH(32), .BLOCK_SIZE(8)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .A(a1), .B(b1),
    .Cin(cin1), .SUB(sub1), .out_valid(ov1), .out_ready(or1), .S(s1),
    .Cout(cout1), .Ovf(ovf1), .busy(bsy1)
  );

  int checks = 0;
  int errors = 0;

  bit           started [2];
  bit           pend    [2];
  int           age     [2];
  logic [129:0] expv    [2];
  logic [129:0] last    [2];
  int           accepts [2];
  int           chunks  [2] = '{4, 1};
  int           widths  [2] = '{128, 32};

  // Returns {Ovf, Cout, S} from plain integer arithmetic on w-bit operands.
  function automatic logic [129:0] model(input logic [127:0] a, input logic [127:0] b,
                                         input logic cin, input logic sub, input int w);
    logic [131:0]        ua, ub, uc, md, us;
    logic signed [131:0] sa, sb, sc, ss, half;
    logic                co, ov;
    md = 132'd1 << w;
    ua = {4'd0, a};
    ub = {4'd0, b};
    uc = {131'd0, cin};
    if (sub) us = md + ua - ub - uc;
    else     us = ua + ub + uc;
    co = (us >= md);
    us = us % md;
    sa = a[w-1] ? ua - md : ua;
    sb = b[w-1] ? ub - md : ub;
    sc = uc;
    ss = sub ? sa - sb - sc : sa + sb + sc;
    half = md >> 1;
    ov = (ss >= half) || (ss < -half);
    return {ov, co, us[127:0]};
  endfunction

  task automatic chk(input string name, input logic [129:0] act, input logic [129:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon(input int d, input logic r, input logic iv, input logic ir,
                     input logic ov, input logic ordy, input logic bsy,
                     input logic [127:0] a, input logic [127:0] b, input logic cin,
                     input logic sub, input logic [127:0] s, input logic cout,
                     input logic ovf);
    logic exp_ov, exp_busy, exp_ir;
    exp_ov   = pend[d] && (age[d] == chunks[d]);
    exp_busy = pend[d] && (age[d] < chunks[d]);
    exp_ir   = !pend[d] || (exp_ov && ordy);
    if (started[d]) begin
      chk($sformatf("dut%0d out_valid", d), 130'(ov), 130'(exp_ov));
      chk($sformatf("dut%0d busy", d), 130'(bsy), 130'(exp_busy));
      chk($sformatf("dut%0d in_ready", d), 130'(ir), 130'(exp_ir));
      chk($sformatf("dut%0d result", d), {ovf, cout, s}, last[d]);
    end
    if (r) begin
      started[d] = 1'b1;
      pend[d]    = 1'b0;
      age[d]     = 0;
      last[d]    = '0;
    end else if (started[d]) begin
      if (pend[d] && age[d] < chunks[d]) begin
        age[d]++;
        if (age[d] == chunks[d]) last[d] = expv[d];
      end
      if (exp_ov && ordy) pend[d] = 1'b0;
      if (iv && exp_ir) begin
        pend[d] = 1'b1;
        age[d]  = 0;
        expv[d] = model(a, b, cin, sub, widths[d]);
        accepts[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, rst0, iv0, ir0, ov0, or0, bsy0, a0, b0, cin0, sub0, s0, cout0, ovf0);
    mon(1, rst1, iv1, ir1, ov1, or1, bsy1, {96'd0, a1}, {96'd0, b1}, cin1, sub1,
        {96'd0, s1}, cout1, ovf1);
  end

  function automatic logic [127:0] pick();
    logic [127:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b0, {127{1'b1}}};
      3:       v = {1'b1, 127'd0};
      default: v = {$urandom, $urandom, $urandom, $urandom};
    endcase
    return v;
  endfunction

  // Presents operands, waits for the accept edge, then waits for out_valid.
  task automatic do_op(input logic [127:0] a, input logic [127:0] b, input logic cin,
                       input logic sub, output int lat, output int busy_n);
    int n;
    @(posedge clk); #1;
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; iv0 = 1'b1;
    n = 0;
    while (!ir0 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    iv0 = 1'b0;
    lat = 0; busy_n = 0;
    while (!ov0 && lat < 50) begin
      if (bsy0) busy_n++;
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic run0();
    int lat, bn;
    logic [129:0] sv;
    bit stable;
    rst0 = 1'b1; iv0 = 1'b0; or0 = 1'b1; a0 = '0; b0 = '0; cin0 = 1'b0; sub0 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst0 = 1'b0;
    chk("reset in_ready", 130'(ir0), 130'(1));
    chk("reset out_valid", 130'(ov0), 130'(0));
    chk("reset busy", 130'(bsy0), 130'(0));
    chk("reset result", {ovf0, cout0, s0}, 130'd0);

    do_op(128'd1, 128'd2, 1'b0, 1'b0, lat, bn);
    chk("add latency", 130'(lat), 130'(4));
    chk("add busy cycles", 130'(bn), 130'(4));
    chk("add 1+2", {ovf0, cout0, s0}, {2'b00, 128'd3});

    do_op('1, 128'd0, 1'b1, 1'b0, lat, bn);
    chk("ripple all ones", {ovf0, cout0, s0}, {2'b01, 128'd0});
    do_op({1'b0, {127{1'b1}}}, 128'd1, 1'b0, 1'b0, lat, bn);
    chk("ripple ovf", {ovf0, cout0, s0}, {2'b10, 1'b1, 127'd0});

    do_op(128'd5, 128'd7, 1'b0, 1'b1, lat, bn);
    chk("sub 5-7", {ovf0, cout0, s0}, {2'b00, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE});
    do_op(128'd7, 128'd5, 1'b1, 1'b1, lat, bn);
    chk("sub 7-5-1", {ovf0, cout0, s0}, {2'b01, 128'd1});

    // backpressure then back-to-back
    @(posedge clk); #1 or0 = 1'b0;
    do_op(128'd100, 128'd23, 1'b0, 1'b0, lat, bn);
    sv = {ovf0, cout0, s0};
    chk("bp result", sv, {2'b00, 128'd123});
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if ({ovf0, cout0, s0} !== sv || ir0 !== 1'b0 || ov0 !== 1'b1) stable = 1'b0;
    end
    chk("bp hold", 130'(stable), 130'(1));
    a0 = 128'd10; b0 = 128'd20; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1; or0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    chk("b2b busy", 130'(bsy0), 130'(1));
    chk("b2b out_valid", 130'(ov0), 130'(0));
    lat = 0;
    while (!ov0 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    chk("b2b latency", 130'(lat), 130'(4));
    chk("b2b 10+20", {ovf0, cout0, s0}, {2'b00, 128'd30});

    // reset mid-run at counter 2
    a0 = 128'd55; b0 = 128'd66; iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst0 = 1'b1;
    @(posedge clk); #1 rst0 = 1'b0;
    chk("abort out_valid", 130'(ov0), 130'(0));
    chk("abort S", 130'(s0), 130'(0));
    chk("abort in_ready", 130'(ir0), 130'(1));
    do_op(128'd3, 128'd4, 1'b0, 1'b0, lat, bn);
    chk("post-abort latency", 130'(lat), 130'(4));
    chk("post-abort 3+4", {ovf0, cout0, s0}, {2'b00, 128'd7});

    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      rst0 = ($urandom_range(0, 599) == 0);
      iv0  = ($urandom_range(0, 2) != 0);
      or0  = ($urandom_range(0, 3) != 0);
      a0 = pick(); b0 = pick();
      cin0 = 1'($urandom); sub0 = 1'($urandom);
    end
    @(posedge clk); #1;
    rst0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
    repeat (8) @(posedge clk);
  endtask

  task automatic run1();
    int c;
    logic [127:0] t;
    rst1 = 1'b1; iv1 = 1'b0; or1 = 1'b1; a1 = '0; b1 = '0; cin1 = 1'b0; sub1 = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst1 = 1'b0;
    c = 0;
    while (accepts[1] < 10000 && c < 40000) begin
      @(posedge clk); #1;
      c++;
      iv1 = ($urandom_range(0, 5) != 0);
      or1 = ($urandom_range(0, 4) != 0);
      t = pick(); a1 = t[127:96];
      t = pick(); b1 = t[31:0];
      cin1 = 1'($urandom); sub1 = 1'($urandom);
    end
    chk("dut1 operation count", 130'(accepts[1] >= 10000), 130'(1));
    @(posedge clk); #1;
    iv1 = 1'b0; or1 = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    fork
      run0();
      run1();
    join
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
